// File: rtl/dma_channel_scheduler.sv
// dma_channel_scheduler: round-robin front end that programs the DMA
// control slave for one requester at a time and watches for completion.
//   iClk, iReset_n          clock, async active-low reset
//   iReq/iSrc/iDst/iLen     per-channel request level and descriptor
//   oAck/oErr               one-cycle completion / watchdog pulses
//   oBusy, oChannel         activity flag and granted channel
//   oDMA_*                  DMA control-slave register write port
//   iDMA_done               DMA write-master done level
module dma_channel_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic [NUM_CH-1:0]   iReq,
  input  logic [32*NUM_CH-1:0] iSrc,
  input  logic [32*NUM_CH-1:0] iDst,
  input  logic [32*NUM_CH-1:0] iLen,
  output logic [NUM_CH-1:0]   oAck,
  output logic [NUM_CH-1:0]   oErr,
  output logic                oBusy,
  output logic [CH_W-1:0]     oChannel,
  output logic                oDMA_chipselect_n,
  output logic                oDMA_write,
  output logic [2:0]          oDMA_address,
  output logic [31:0]         oDMA_writedata,
  input  logic                iDMA_done
);

  localparam logic [31:0] TO = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SRC,
    S_WR_DST,
    S_WR_LEN,
    S_WR_GO,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [31:0]     len_q, len_d;
  logic [31:0]     wdog_q, wdog_d;
  logic            done_q;

  logic            gnt_vld;
  logic [CH_W-1:0] gnt_idx;
  logic [CH_W:0]   rr_sum;
  logic [CH_W-1:0] rr_idx;
  logic [31:0]     sel_src, sel_dst, sel_len;
  logic [NUM_CH-1:0] ch_oh;
  logic            done_edge;

  // Scan from the farthest offset down so the nearest set bit
  // after the pointer is the one left standing.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    rr_idx  = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      rr_sum = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (rr_sum >= (CH_W+1)'(NUM_CH))
        rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
      rr_idx = rr_sum[CH_W-1:0];
      if (iReq[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx;
      end
    end
  end

  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    sel_len = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_idx == CH_W'(k)) begin
        sel_src = iSrc[32*k +: 32];
        sel_dst = iDst[32*k +: 32];
        sel_len = iLen[32*k +: 32];
      end
    end
  end

  assign ch_oh     = NUM_CH'(1) << ch_q;
  // Only a fresh rising edge counts; a level left high by the
  // previous transfer must not complete the current one.
  assign done_edge = iDMA_done & ~done_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    wdog_d  = wdog_q;
    oAck    = '0;
    oErr    = '0;
    oDMA_chipselect_n = 1'b1;
    oDMA_write        = 1'b0;
    oDMA_address      = 3'd0;
    oDMA_writedata    = 32'd0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          ch_d    = gnt_idx;
          ptr_d   = gnt_idx;
          src_d   = sel_src;
          dst_d   = sel_dst;
          len_d   = sel_len;
          state_d = (sel_len == 32'd0) ? S_DONE : S_WR_SRC;
        end
      end
      S_WR_SRC: begin
        oDMA_chipselect_n = 1'b0;
        oDMA_write        = 1'b1;
        oDMA_address      = 3'd0;
        oDMA_writedata    = src_q;
        state_d           = S_WR_DST;
      end
      S_WR_DST: begin
        oDMA_chipselect_n = 1'b0;
        oDMA_write        = 1'b1;
        oDMA_address      = 3'd1;
        oDMA_writedata    = dst_q;
        state_d           = S_WR_LEN;
      end
      S_WR_LEN: begin
        oDMA_chipselect_n = 1'b0;
        oDMA_write        = 1'b1;
        oDMA_address      = 3'd2;
        oDMA_writedata    = len_q;
        state_d           = S_WR_GO;
      end
      S_WR_GO: begin
        oDMA_chipselect_n = 1'b0;
        oDMA_write        = 1'b1;
        oDMA_address      = 3'd3;
        oDMA_writedata    = 32'd1;
        state_d           = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 32'd1;
        if (done_edge)
          state_d = S_DONE;
        else if (TO != 32'd0 && wdog_d == TO)
          state_d = S_ERR;
      end
      S_DONE: begin
        oAck    = ch_oh;
        wdog_d  = '0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        oErr    = ch_oh;
        wdog_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      ptr_q   <= CH_W'(NUM_CH - 1);
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      wdog_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      wdog_q  <= wdog_d;
      done_q  <= iDMA_done;
    end
  end

  assign oBusy    = (state_q != S_IDLE);
  assign oChannel = ch_q;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// tb_dma_channel_scheduler: directed bench for dma_channel_scheduler.
// u_dut uses the default watchdog, u_wd a 16-cycle one.
module tb_dma_channel_scheduler;

  logic         iClk = 1'b0;
  logic         iReset_n;
  logic [3:0]   iReq;
  logic [127:0] iSrc, iDst, iLen;
  logic         iDMA_done;

  logic [3:0]  ack, err;
  logic        busy, cs_n, wr;
  logic [1:0]  ch;
  logic [2:0]  addr;
  logic [31:0] wdata;

  logic [3:0]  w_ack, w_err;
  logic        w_busy, w_cs_n, w_wr;
  logic [1:0]  w_ch;
  logic [2:0]  w_addr;
  logic [31:0] w_wdata;

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] seen;

  always #5 iClk = ~iClk;

  dma_channel_scheduler #(
    .NUM_CH(4), .CH_W(2), .TIMEOUT(65535)
  ) u_dut (
    .iClk(iClk), .iReset_n(iReset_n),
    .iReq(iReq), .iSrc(iSrc), .iDst(iDst), .iLen(iLen),
    .oAck(ack), .oErr(err), .oBusy(busy), .oChannel(ch),
    .oDMA_chipselect_n(cs_n), .oDMA_write(wr),
    .oDMA_address(addr), .oDMA_writedata(wdata),
    .iDMA_done(iDMA_done)
  );

  dma_channel_scheduler #(
    .NUM_CH(4), .CH_W(2), .TIMEOUT(16)
  ) u_wd (
    .iClk(iClk), .iReset_n(iReset_n),
    .iReq(iReq), .iSrc(iSrc), .iDst(iDst), .iLen(iLen),
    .oAck(w_ack), .oErr(w_err), .oBusy(w_busy), .oChannel(w_ch),
    .oDMA_chipselect_n(w_cs_n), .oDMA_write(w_wr),
    .oDMA_address(w_addr), .oDMA_writedata(w_wdata),
    .iDMA_done(iDMA_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset;
    iReset_n  = 1'b0;
    iReq      = '0;
    iDMA_done = 1'b0;
    ticks(2);
    iReset_n  = 1'b1;
  endtask

  task automatic set_desc(input int k, input logic [31:0] s,
                          input logic [31:0] d, input logic [31:0] l);
    iSrc[32*k +: 32] = s;
    iDst[32*k +: 32] = d;
    iLen[32*k +: 32] = l;
  endtask

  task automatic rr_xfer(input int c);
    tick();
    chk("rr_ch", 32'(ch), 32'(c));
    chk("rr_src", wdata, 32'h100 * 32'(c + 1));
    ticks(4);
    iDMA_done = 1'b1;
    tick();
    chk("rr_ack", 32'(ack), 32'(1) << c);
    iDMA_done = 1'b0;
    tick();
    chk("rr_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    iReset_n  = 1'b0;
    iReq      = '0;
    iDMA_done = 1'b0;
    iSrc = '0;
    iDst = '0;
    iLen = '0;
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ch", 32'(ch), 32'd0);
    chk("rst_csn", 32'(cs_n), 32'd1);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wd_busy", 32'(w_busy), 32'd0);

    // single transfer on channel 0
    do_reset();
    set_desc(0, 32'h1000, 32'h2000, 32'd64);
    iReq = 4'b0001;
    tick();
    chk("s_csn", 32'(cs_n), 32'd0);
    chk("s_wr", 32'(wr), 32'd1);
    chk("s_a0", 32'(addr), 32'd0);
    chk("s_d0", wdata, 32'h1000);
    chk("s_busy", 32'(busy), 32'd1);
    iDst[31:0] = 32'hDEAD_BEEF;
    tick();
    chk("s_a1", 32'(addr), 32'd1);
    chk("s_d1", wdata, 32'h2000);
    tick();
    chk("s_a2", 32'(addr), 32'd2);
    chk("s_d2", wdata, 32'd64);
    tick();
    chk("s_a3", 32'(addr), 32'd3);
    chk("s_d3", wdata, 32'd1);
    tick();
    chk("s_wait_csn", 32'(cs_n), 32'd1);
    seen = '0;
    for (int i = 0; i < 19; i++) begin
      tick();
      seen = seen | ack;
    end
    chk("s_early_ack", 32'(seen), 32'd0);
    iDMA_done = 1'b1;
    tick();
    chk("s_ack", 32'(ack), 32'b0001);
    iReq = 4'b0000;
    tick();
    chk("s_busy_end", 32'(busy), 32'd0);
    chk("s_ack_end", 32'(ack), 32'd0);

    // round robin with all channels requesting
    do_reset();
    for (int k = 0; k < 4; k++)
      set_desc(k, 32'h100 * 32'(k + 1), 32'h9000, 32'd8);
    iReq = 4'b1111;
    for (int i = 0; i < 5; i++) rr_xfer(i % 4);
    iReq = 4'b0000;
    tick();

    // stale done level from previous transfer
    do_reset();
    set_desc(1, 32'h3000, 32'h4000, 32'd16);
    iReq = 4'b0010;
    ticks(5);
    iDMA_done = 1'b1;
    tick();
    chk("st_ack1", 32'(ack), 32'b0010);
    ticks(2);
    chk("st_regrant_ch", 32'(ch), 32'd1);
    chk("st_regrant_csn", 32'(cs_n), 32'd0);
    ticks(4);
    seen = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | ack;
    end
    chk("st_no_ack", 32'(seen), 32'd0);
    iDMA_done = 1'b0;
    tick();
    chk("st_no_ack_low", 32'(ack), 32'd0);
    iDMA_done = 1'b1;
    tick();
    chk("st_ack2", 32'(ack), 32'b0010);
    iReq = 4'b0000;
    iDMA_done = 1'b0;
    tick();

    // zero length on channel 2
    do_reset();
    set_desc(2, 32'h5000, 32'h6000, 32'd0);
    iReq = 4'b0100;
    tick();
    chk("z_ack", 32'(ack), 32'b0100);
    chk("z_csn", 32'(cs_n), 32'd1);
    iReq = 4'b0000;
    tick();
    chk("z_busy", 32'(busy), 32'd0);

    // done edge coinciding with watchdog expiry
    do_reset();
    set_desc(1, 32'hA000, 32'hB000, 32'd4);
    iReq = 4'b0010;
    ticks(5);
    ticks(15);
    iDMA_done = 1'b1;
    tick();
    chk("tie_ack", 32'(w_ack), 32'b0010);
    chk("tie_err", 32'(w_err), 32'd0);
    iReq = 4'b0000;
    iDMA_done = 1'b0;
    tick();

    // watchdog expiry on channel 0
    do_reset();
    set_desc(0, 32'h7000, 32'h8000, 32'd32);
    iReq = 4'b0001;
    ticks(5);
    ticks(15);
    chk("wd_err_early", 32'(w_err), 32'd0);
    chk("wd_busy", 32'(w_busy), 32'd1);
    tick();
    chk("wd_err", 32'(w_err), 32'b0001);
    chk("wd_no_ack", 32'(w_ack), 32'd0);
    iReq = 4'b0000;
    tick();
    chk("wd_idle", 32'(w_busy), 32'd0);
    chk("wd_err_end", 32'(w_err), 32'd0);

    // asynchronous reset while u_dut waits on channel 0
    chk("rm_busy_before", 32'(busy), 32'd1);
    iReq = 4'b0101;
    iReset_n = 1'b0;
    #1;
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_csn", 32'(cs_n), 32'd1);
    chk("rm_ack", 32'(ack), 32'd0);
    tick();
    iReset_n = 1'b1;
    tick();
    chk("rm_grant_ch", 32'(ch), 32'd0);
    chk("rm_grant_src", wdata, 32'h7000);
    iReq = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
